// File: rtl/hyperbus_target.sv
// hyperbus_target: HyperBus follower that emulates a HyperRAM part for
// loopback/regression of the HyperBus leader controller.
//
// Decodes the 48-bit command/address, applies the initial latency, and
// serves linear or wrapped bursts to an internal RAM (2^DEPTH_LOG2 words of
// 2*WIDTH bits) or to a small register space (ID0 at 0, CR0 at 0x800).
//
// Ports:
//   clk90      free-running memory clock (same clock the leader gates onto CK)
//   rst        asynchronous active-high reset
//   hbus_ck    gated bus clock from the leader
//   hbus_rstn  device reset, active low, sampled on posedge clk90 (RAM kept)
//   hbus_csn   chip select, active low
//   hbus_dq    DDR data / command-address bus
//   hbus_rwds  read strobe (out) / write mask (in) / latency indicator (out)
//   cr0_o      current configuration register 0
//   busy       transaction in progress
//   err        sticky protocol error flag
module hyperbus_target #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned DEPTH_LOG2     = 10,
  parameter int unsigned TACC_COUNT     = 6,
  parameter bit          DOUBLE_LATENCY = 1'b1,
  parameter int unsigned WRAP_LEN       = 16,
  parameter logic [15:0] ID0_VALUE      = 16'h0C81,
  parameter logic [15:0] CR0_RESET      = 16'h8F1F
) (
  input  logic             clk90,
  input  logic             rst,
  input  logic             hbus_ck,
  input  logic             hbus_rstn,
  input  logic             hbus_csn,
  inout  wire  [WIDTH-1:0] hbus_dq,
  inout  wire              hbus_rwds,
  output logic [15:0]      cr0_o,
  output logic             busy,
  output logic             err
);

  localparam int unsigned W2  = 2 * WIDTH;
  localparam int unsigned CAW = 48 - W2;
  localparam int unsigned LW  = $clog2(2 * TACC_COUNT + 1);
  localparam logic [LW-1:0] LAT_INIT =
    DOUBLE_LATENCY ? LW'(2 * TACC_COUNT - 1) : LW'(TACC_COUNT - 1);
  localparam logic [31:0] LIN_MASK  = 32'((64'd1 << DEPTH_LOG2) - 64'd1);
  localparam logic [31:0] WRAP_MASK = 32'(WRAP_LEN - 1);
  localparam logic [31:0] CR0_ADDR  = 32'h0000_0800;

  typedef enum logic [2:0] {IDLE, CA, LAT, READ, WRITE} state_t;

  state_t              state;
  logic [WIDTH-1:0]    dq_r, dq_f;
  logic                rwds_r, rwds_f;
  logic                ck_act, csn_f;
  logic [CAW-1:0]      ca;
  logic [1:0]          ca_cnt;
  logic [31:0]         addr;
  logic                rw, as, linear;
  logic [LW-1:0]       lat_cnt;
  logic [W2-1:0]       rd_word;
  logic                dq_oe, rwds_oe;
  logic                reg_done;

  logic [W2-1:0]       mem [0:(1 << DEPTH_LOG2) - 1];

  logic                ck_valid;
  logic [W2-1:0]       word;
  logic [1:0]          mask;
  logic [47:0]         ca_next;
  logic [31:0]         dec_addr;
  logic [31:0]         addr_next;
  logic [31:0]         rd_addr;
  logic [W2-1:0]       rd_data;
  logic                mem_we;
  logic                unused_ca;

  // Upper byte/RWDS on the rising half, lower byte on the falling half.
  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      dq_r   <= '0;
      rwds_r <= 1'b0;
    end else begin
      dq_r   <= hbus_dq;
      rwds_r <= hbus_rwds;
    end
  end

  // ck_act takes the value CK had during the high half of clk90; csn_f
  // qualifies it so a stray CK pulse with CS high is not counted.
  always_ff @(negedge clk90 or posedge rst) begin
    if (rst) begin
      dq_f   <= '0;
      rwds_f <= 1'b0;
      ck_act <= 1'b0;
      csn_f  <= 1'b1;
    end else begin
      dq_f   <= hbus_dq;
      rwds_f <= hbus_rwds;
      ck_act <= hbus_ck;
      csn_f  <= hbus_csn;
    end
  end

  always_comb begin
    ck_valid = ck_act & ~csn_f;
    word     = {dq_r, dq_f};
    mask     = {rwds_r, rwds_f};
    ca_next  = {ca, word};
    dec_addr = {ca_next[44:16], ca_next[2:0]};
    unused_ca = ^ca_next[15:3];
    // Only the bits under the burst mask advance; the rest are held.
    if (linear)
      addr_next = (addr & ~LIN_MASK) | ((addr + 32'd1) & LIN_MASK);
    else
      addr_next = (addr & ~WRAP_MASK) | ((addr + 32'd1) & WRAP_MASK);
    // On entry to READ the current address is fetched; afterwards the
    // word for the following CK cycle is prefetched.
    rd_addr = (state == READ) ? addr_next : addr;
    if (as) begin
      if (rd_addr == 32'h0)
        rd_data = W2'(ID0_VALUE);
      else if (rd_addr == CR0_ADDR)
        rd_data = W2'(cr0_o);
      else
        rd_data = '0;
    end else begin
      rd_data = mem[rd_addr[DEPTH_LOG2-1:0]];
    end
    mem_we = (state == WRITE) && ck_valid && !as && hbus_rstn;
  end

  // RAM has no reset so hbus_rstn leaves its contents intact.
  // Mask bit 1 means the byte is not written.
  always_ff @(posedge clk90) begin
    if (mem_we) begin
      if (!mask[1]) mem[addr[DEPTH_LOG2-1:0]][W2-1:WIDTH] <= word[W2-1:WIDTH];
      if (!mask[0]) mem[addr[DEPTH_LOG2-1:0]][WIDTH-1:0]  <= word[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk90 or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ca       <= '0;
      ca_cnt   <= '0;
      addr     <= '0;
      rw       <= 1'b0;
      as       <= 1'b0;
      linear   <= 1'b0;
      lat_cnt  <= '0;
      rd_word  <= '0;
      dq_oe    <= 1'b0;
      rwds_oe  <= 1'b0;
      reg_done <= 1'b0;
      err      <= 1'b0;
      cr0_o    <= CR0_RESET;
    end else if (!hbus_rstn) begin
      state    <= IDLE;
      ca_cnt   <= '0;
      dq_oe    <= 1'b0;
      rwds_oe  <= 1'b0;
      reg_done <= 1'b0;
      err      <= 1'b0;
      cr0_o    <= CR0_RESET;
    end else begin
      unique case (state)
        IDLE: begin
          if (!hbus_csn) begin
            state   <= CA;
            ca_cnt  <= '0;
            rwds_oe <= 1'b1;
          end
        end
        CA: begin
          if (ck_valid) begin
            ca <= ca_next[CAW-1:0];
            if (ca_cnt == 2'd2) begin
              rw      <= ca_next[47];
              as      <= ca_next[46];
              linear  <= ca_next[45];
              addr    <= dec_addr;
              rwds_oe <= 1'b0;
              if (!ca_next[47] && ca_next[46]) begin
                state    <= WRITE;
                reg_done <= 1'b0;
              end else begin
                state   <= LAT;
                lat_cnt <= LAT_INIT;
              end
            end else begin
              ca_cnt <= ca_cnt + 2'd1;
            end
          end
        end
        LAT: begin
          if (ck_valid) begin
            if (lat_cnt == '0) begin
              if (rw) begin
                state   <= READ;
                dq_oe   <= 1'b1;
                rwds_oe <= 1'b1;
                rd_word <= rd_data;
              end else begin
                state <= WRITE;
              end
            end else begin
              lat_cnt <= lat_cnt - 1'b1;
            end
          end
        end
        READ: begin
          if (ck_valid) begin
            addr    <= addr_next;
            rd_word <= rd_data;
          end
        end
        WRITE: begin
          if (ck_valid) begin
            addr <= addr_next;
            // Register writes ignore the byte mask; only the first word
            // lands, anything after it is a protocol error.
            if (as) begin
              if (reg_done) begin
                err <= 1'b1;
              end else begin
                reg_done <= 1'b1;
                if (addr == CR0_ADDR) cr0_o <= 16'(word);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Evaluated after capture so a word in the final CK cycle still lands.
      if (hbus_csn) begin
        state   <= IDLE;
        dq_oe   <= 1'b0;
        rwds_oe <= 1'b0;
        if (state == CA || (state == LAT && !rw && !as)) err <= 1'b1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign hbus_dq   = dq_oe ? (clk90 ? rd_word[W2-1:WIDTH] : rd_word[WIDTH-1:0]) : 'z;
  assign hbus_rwds = rwds_oe ? (dq_oe ? clk90 : DOUBLE_LATENCY) : 1'bz;

endmodule

// File: tb/tb_hyperbus_target.sv
`timescale 1ns/1ps
module tb_hyperbus_target;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned WRAP  = 16;
  localparam int unsigned LAT   = 12;

  logic        clk90 = 1'b0;
  logic        rst, hbus_ck, hbus_rstn, hbus_csn;
  logic [7:0]  tb_dq;
  logic        tb_dq_oe, tb_rwds, tb_rwds_oe;
  wire  [7:0]  hbus_dq;
  wire         hbus_rwds;
  logic [15:0] cr0_o;
  logic        busy, err;

  assign hbus_dq   = tb_dq_oe   ? tb_dq   : 'z;
  assign hbus_rwds = tb_rwds_oe ? tb_rwds : 1'bz;

  always #5 clk90 = ~clk90;

  hyperbus_target #(
    .WIDTH(8), .DEPTH_LOG2(10), .TACC_COUNT(6), .DOUBLE_LATENCY(1'b1),
    .WRAP_LEN(16), .ID0_VALUE(16'h0C81), .CR0_RESET(16'h8F1F)
  ) dut (
    .clk90(clk90), .rst(rst), .hbus_ck(hbus_ck), .hbus_rstn(hbus_rstn),
    .hbus_csn(hbus_csn), .hbus_dq(hbus_dq), .hbus_rwds(hbus_rwds),
    .cr0_o(cr0_o), .busy(busy), .err(err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] wbuf  [16];
  logic [1:0]  mbuf  [16];
  logic [15:0] rbuf  [16];
  logic [1:0]  rsbuf [16];
  logic        ca_rwds_ok, end_busy, end_oe;

  // Reference memory: per-byte contents plus a "has been written" flag.
  logic [15:0] mm [DEPTH];
  bit          kh [DEPTH];
  bit          kl [DEPTH];

  typedef struct {
    string           name;
    bit              rd;
    bit              asp;
    bit              lin;
    logic [31:0]     addr;
    int unsigned     n;
    logic [3:0][15:0] data;
    logic [1:0]      mask;
  } vec_t;
  vec_t vq[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] next_addr(input logic [31:0] a, input bit lin);
    int unsigned g;
    g = lin ? DEPTH : WRAP;
    return (a / g) * g + ((a % g) + 1) % g;
  endfunction

  task automatic model_write(input logic [31:0] a0, input bit lin, input int unsigned n);
    logic [31:0] a;
    int unsigned idx;
    a = a0;
    for (int unsigned i = 0; i < n; i++) begin
      idx = a % DEPTH;
      if (!mbuf[i][1]) begin mm[idx][15:8] = wbuf[i][15:8]; kh[idx] = 1'b1; end
      if (!mbuf[i][0]) begin mm[idx][7:0]  = wbuf[i][7:0];  kl[idx] = 1'b1; end
      a = next_addr(a, lin);
    end
  endtask

  // One CK cycle; entered just after a falling clk90 edge, returns just
  // after the next falling edge. Samples whatever is on DQ/RWDS per half.
  task automatic ck_cycle(input logic [15:0] w, input logic [1:0] m, input bit drv_dq,
                          input bit drv_rwds, output logic [15:0] rd, output logic [1:0] rs);
    tb_dq = w[15:8]; tb_rwds = m[1]; tb_dq_oe = drv_dq; tb_rwds_oe = drv_rwds;
    @(posedge clk90); #1;
    hbus_ck = 1'b1;
    rd[15:8] = hbus_dq; rs[1] = hbus_rwds;
    tb_dq = w[7:0]; tb_rwds = m[0];
    @(negedge clk90); #1;
    hbus_ck = 1'b0;
    rd[7:0] = hbus_dq; rs[0] = hbus_rwds;
  endtask

  task automatic send_ca(input bit rd, input bit asp, input bit lin, input logic [31:0] a,
                         input int unsigned words);
    logic [47:0] ca;
    logic [15:0] d;
    logic [1:0]  s;
    ca = {rd, asp, lin, a[31:3], 13'd0, a[2:0]};
    ca_rwds_ok = 1'b1;
    hbus_csn = 1'b0;
    for (int unsigned i = 0; i < words; i++) begin
      ck_cycle(ca[47 - 16*i -: 16], 2'b00, 1'b1, 1'b0, d, s);
      if (s != 2'b11) ca_rwds_ok = 1'b0;
    end
  endtask

  task automatic xfer(input bit rd, input bit asp, input bit lin, input logic [31:0] a,
                      input int unsigned n);
    logic [15:0] d;
    logic [1:0]  s;
    int unsigned lat;
    send_ca(rd, asp, lin, a, 3);
    lat = (!rd && asp) ? 0 : LAT;
    for (int unsigned i = 0; i < lat; i++) ck_cycle(16'h0, 2'b00, 1'b0, 1'b0, d, s);
    for (int unsigned i = 0; i < n; i++) begin
      if (rd) begin
        ck_cycle(16'h0, 2'b00, 1'b0, 1'b0, d, s);
        rbuf[i] = d; rsbuf[i] = s;
      end else begin
        ck_cycle(wbuf[i], mbuf[i], 1'b1, 1'b1, d, s);
      end
    end
    hbus_csn = 1'b1; tb_dq_oe = 1'b0; tb_rwds_oe = 1'b0;
    @(posedge clk90); #1;
    end_busy = busy;
    end_oe   = dut.dq_oe | dut.rwds_oe;
    @(negedge clk90); #1;
  endtask

  task automatic add_vec(input string nm, input bit rd, input bit asp, input bit lin,
                         input logic [31:0] a, input int unsigned n,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3, input logic [1:0] m);
    vec_t v;
    v.name = nm; v.rd = rd; v.asp = asp; v.lin = lin; v.addr = a; v.n = n;
    v.data = {d3, d2, d1, d0}; v.mask = m;
    vq.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d;
    logic [1:0]  s;
    logic [31:0] a;
    logic [15:0] care;
    bit          rd, lin;
    int unsigned n, idx;

    rst = 1'b1; hbus_rstn = 1'b1; hbus_csn = 1'b1; hbus_ck = 1'b0;
    tb_dq = '0; tb_dq_oe = 1'b0; tb_rwds = 1'b0; tb_rwds_oe = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin mm[i] = '0; kh[i] = 0; kl[i] = 0; end

    #12;
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_cr0", cr0_o, 16'h8F1F);
    check("reset_oe", dut.dq_oe | dut.rwds_oe, 1'b0);
    @(negedge clk90); rst = 1'b0;
    @(negedge clk90); #1;

    //        name          rd asp lin addr           n  data...                                   mask
    add_vec("id0",          1, 1, 1, 32'h0000_0000, 1, 16'h0C81, 16'h0,    16'h0,    16'h0,    2'b00);
    add_vec("cr0_rd",       1, 1, 1, 32'h0000_0800, 1, 16'h8F1F, 16'h0,    16'h0,    16'h0,    2'b00);
    add_vec("wr4",          0, 0, 1, 32'h0000_0010, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b00);
    add_vec("rd4",          1, 0, 1, 32'h0000_0010, 4, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2'b00);
    add_vec("pre_aaaa",     0, 0, 1, 32'h0000_0020, 1, 16'hAAAA, 16'h0,    16'h0,    16'h0,    2'b00);
    add_vec("mask01_wr",    0, 0, 1, 32'h0000_0020, 1, 16'h5555, 16'h0,    16'h0,    16'h0,    2'b01);
    add_vec("mask01_rd",    1, 0, 1, 32'h0000_0020, 1, 16'h55AA, 16'h0,    16'h0,    16'h0,    2'b00);
    add_vec("wr_top",       0, 0, 1, 32'h0000_03FF, 3, 16'hBEEF, 16'h0123, 16'h4567, 16'h0,    2'b00);
    add_vec("rd_lin_wrap",  1, 0, 1, 32'h0000_03FF, 3, 16'hBEEF, 16'h0123, 16'h4567, 16'h0,    2'b00);
    add_vec("wr_1e",        0, 0, 1, 32'h0000_001E, 2, 16'h1E1E, 16'h1F1F, 16'h0,    16'h0,    2'b00);
    add_vec("rd_wrapped",   1, 0, 0, 32'h0000_001E, 3, 16'h1E1E, 16'h1F1F, 16'h1111, 16'h0,    2'b00);

    foreach (vq[v]) begin
      for (int unsigned i = 0; i < vq[v].n; i++) begin
        wbuf[i] = vq[v].data[i]; mbuf[i] = vq[v].mask;
      end
      xfer(vq[v].rd, vq[v].asp, vq[v].lin, vq[v].addr, vq[v].n);
      if (!vq[v].rd && !vq[v].asp) model_write(vq[v].addr, vq[v].lin, vq[v].n);
      if (vq[v].rd) begin
        for (int unsigned i = 0; i < vq[v].n; i++) begin
          check({vq[v].name, "_data"}, rbuf[i], vq[v].data[i]);
          check({vq[v].name, "_rwds"}, rsbuf[i], 2'b10);
        end
      end
      check({vq[v].name, "_ca_rwds"}, ca_rwds_ok, 1'b1);
      check({vq[v].name, "_err"}, err, 1'b0);
      check({vq[v].name, "_idle"}, {end_busy, end_oe}, 2'b00);
    end

    // CR0 register write: no latency, lands one clk90 cycle after its CK cycle.
    send_ca(1'b0, 1'b1, 1'b0, 32'h0000_0800, 3);
    ck_cycle(16'h8F0F, 2'b00, 1'b1, 1'b1, d, s);
    check("cr0_wr_before", cr0_o, 16'h8F1F);
    @(posedge clk90); #1;
    check("cr0_wr_after", cr0_o, 16'h8F0F);
    check("cr0_wr_busy", busy, 1'b1);
    hbus_csn = 1'b1; tb_dq_oe = 1'b0; tb_rwds_oe = 1'b0;
    @(posedge clk90); #1;
    check("cr0_wr_idle", busy, 1'b0);
    check("cr0_wr_err", err, 1'b0);
    @(negedge clk90); #1;

    // Extra words after a register write are ignored and flagged.
    wbuf[0] = 16'h8F0F; wbuf[1] = 16'h1234; mbuf[0] = 2'b00; mbuf[1] = 2'b00;
    xfer(1'b0, 1'b1, 1'b0, 32'h0000_0800, 2);
    check("regwr_extra_err", err, 1'b1);
    check("regwr_extra_cr0", cr0_o, 16'h8F0F);

    // Device reset clears flags and CR0 but keeps RAM.
    hbus_rstn = 1'b0;
    repeat (2) @(posedge clk90);
    @(negedge clk90); #1;
    hbus_rstn = 1'b1;
    check("rstn_err", err, 1'b0);
    check("rstn_cr0", cr0_o, 16'h8F1F);
    check("rstn_busy", busy, 1'b0);
    xfer(1'b1, 1'b0, 1'b1, 32'h0000_0010, 1);
    check("rstn_ram_kept", rbuf[0], 16'h1111);

    // Abort after two CA words.
    send_ca(1'b1, 1'b0, 1'b1, 32'h0000_0010, 2);
    hbus_csn = 1'b1; tb_dq_oe = 1'b0;
    @(posedge clk90); #1;
    check("abort_busy", busy, 1'b0);
    check("abort_err", err, 1'b1);
    check("abort_oe", dut.dq_oe | dut.rwds_oe, 1'b0);
    @(negedge clk90); #1;
    xfer(1'b1, 1'b1, 1'b1, 32'h0000_0000, 1);
    check("abort_next_id0", rbuf[0], 16'h0C81);
    check("abort_next_idle", end_busy, 1'b0);

    // Randomised bursts against the reference memory.
    for (int unsigned t = 0; t < 50; t++) begin
      rd  = (t >= 8) && ($urandom_range(0, 1) == 1);
      lin = ($urandom_range(0, 1) == 1);
      n   = $urandom_range(1, 8);
      a   = $urandom;
      if ($urandom_range(0, 3) == 0) a[9:0] = 10'h3F8 + 10'($urandom_range(0, 7));
      else                           a[9:0] = 10'h100 + 10'($urandom_range(0, 63));
      if (!rd) begin
        for (int unsigned i = 0; i < n; i++) begin
          wbuf[i] = 16'($urandom);
          mbuf[i] = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
        end
      end
      xfer(rd, 1'b0, lin, a, n);
      if (!rd) begin
        model_write(a, lin, n);
      end else begin
        for (int unsigned i = 0; i < n; i++) begin
          idx  = a % DEPTH;
          care = {kh[idx] ? 8'hFF : 8'h00, kl[idx] ? 8'hFF : 8'h00};
          if (care != 16'h0) check("rand_rd_data", rbuf[i] & care, mm[idx] & care);
          check("rand_rd_rwds", rsbuf[i], 2'b10);
          a = next_addr(a, lin);
        end
      end
      check("rand_idle", {end_busy, end_oe}, 2'b00);
    end
    check("rand_err", err, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
